// File: rtl/imem_prog.sv
// imem_prog: instruction memory with a registered fetch port and a handshaked program-load port
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   rd_en, read_address             fetch request and word address
//   instruction, instr_valid,       registered fetch data, fetch-completed flag,
//   addr_err                        out-of-range flag of the last completed fetch
//   prog_start, prog_valid,         enter LOAD, load-word strobe,
//   prog_data, prog_last            load word, final-word qualifier
//   prog_ready, prog_busy,          load port accepting (LOAD), fetches blocked (LOAD),
//   prog_done, prog_len             1-cycle end-of-load pulse, words written by the last load
module imem_prog #(
   parameter int INSTR_W = 8,
   parameter int DEPTH   = 32,
   parameter int ADDR_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  read_address,
   output logic [INSTR_W-1:0] instruction,
   output logic               instr_valid,
   output logic               addr_err,
   input  logic               prog_start,
   input  logic               prog_valid,
   input  logic [INSTR_W-1:0] prog_data,
   input  logic               prog_last,
   output logic               prog_ready,
   output logic               prog_busy,
   output logic               prog_done,
   output logic [ADDR_W:0]    prog_len
);
   localparam int AW = $clog2(DEPTH);
   // default program, word 0 in the low byte; shifting past it yields the zero fill
   localparam logic [39:0] IMG = 40'h4D_A9_18_C1_49;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);
   typedef enum logic {RUN, LOAD} state_t;
   state_t state, state_nxt;
   logic [INSTR_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wptr;
   logic accept, last_word, fetch, in_range;

   always_ff @(posedge clk)
      if (reset) state <= RUN;
      else state <= state_nxt;

   always_comb
      state_nxt = state == RUN ? (prog_start ? LOAD : RUN) : (last_word ? RUN : LOAD);

   always_comb begin
      prog_ready = state == LOAD;
      prog_busy  = state == LOAD;
      accept     = prog_valid && state == LOAD;
      last_word  = accept && (prog_last || wptr == LAST);
      // prog_start takes priority and drops a same-cycle fetch
      fetch      = state == RUN && rd_en && !prog_start;
      in_range   = {1'b0, read_address} < LIMIT;
   end

   always_ff @(posedge clk)
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= INSTR_W'(8'(IMG >> (8*i)));
         instruction <= '0;
         instr_valid <= 1'b0;
         addr_err    <= 1'b0;
         prog_done   <= 1'b0;
         prog_len    <= (ADDR_W+1)'(5);
         wptr        <= '0;
      end else begin
         instr_valid <= fetch;
         prog_done   <= last_word;
         if (fetch) begin
            instruction <= in_range ? mem[read_address[AW-1:0]] : '0;
            addr_err    <= !in_range;
         end
         if (state == RUN && prog_start) wptr <= '0;
         else if (accept) wptr <= wptr + ADDR_W'(1);
         if (accept) mem[wptr[AW-1:0]] <= prog_data;
         if (last_word) prog_len <= {1'b0, wptr} + (ADDR_W+1)'(1);
      end
endmodule

// File: tb/tb_imem_prog.sv
// tb_imem_prog: directed stimulus, per-cycle compare against a behavioural model, literal spot checks
module tb_imem_prog;
   logic       clk = 1'b0;
   logic       reset = 1'b1, rd_en = 1'b0, prog_start = 1'b0, prog_valid = 1'b0, prog_last = 1'b0;
   logic [7:0] read_address = '0, prog_data = '0;
   logic [7:0] instruction;
   logic       instr_valid, addr_err, prog_ready, prog_busy, prog_done;
   logic [8:0] prog_len;
   int         vectors = 0, miscompares = 0;

   imem_prog dut (
      .clk(clk), .reset(reset), .rd_en(rd_en), .read_address(read_address),
      .instruction(instruction), .instr_valid(instr_valid), .addr_err(addr_err),
      .prog_start(prog_start), .prog_valid(prog_valid), .prog_data(prog_data),
      .prog_last(prog_last), .prog_ready(prog_ready), .prog_busy(prog_busy),
      .prog_done(prog_done), .prog_len(prog_len)
   );

   initial forever #5 clk = ~clk;

   // behavioural model: a plain array plus a loading flag and pointer
   int  m_mem [32];
   bit  armed = 0, m_load = 0, m_valid = 0, m_err = 0, m_done = 0;
   int  m_wp = 0, m_instr = 0, m_len = 5;
   byte unsigned img [5] = '{8'h49, 8'hC1, 8'h18, 8'hA9, 8'h4D};

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) m_mem[i] = i < 5 ? int'(img[i]) : 0;
         armed = 1; m_load = 0; m_valid = 0; m_err = 0; m_done = 0;
         m_wp = 0; m_instr = 0; m_len = 5;
      end else begin
         m_done = 0;
         if (!m_load) begin
            if (prog_start) begin
               m_load = 1; m_wp = 0; m_valid = 0;
            end else if (rd_en) begin
               m_valid = 1;
               m_err = read_address >= 32;
               m_instr = m_err ? 0 : m_mem[read_address];
            end else m_valid = 0;
         end else begin
            m_valid = 0;
            if (prog_valid) begin
               m_mem[m_wp] = prog_data;
               if (prog_last || m_wp == 31) begin
                  m_load = 0; m_done = 1; m_len = m_wp + 1;
               end
               m_wp++;
            end
         end
      end
   end

   task automatic cmp(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (armed && !reset) begin
         cmp("instruction", instruction, m_instr);
         cmp("instr_valid", instr_valid, m_valid);
         cmp("addr_err", addr_err, m_err);
         cmp("prog_ready", prog_ready, m_load);
         cmp("prog_busy", prog_busy, m_load);
         cmp("prog_done", prog_done, m_done);
         cmp("prog_len", prog_len, m_len);
      end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic fetch(int a, int exp_i, int exp_e, string name);
      rd_en = 1; read_address = 8'(a);
      cyc();
      rd_en = 0;
      cmp(name, instruction, exp_i);
      cmp({name, "_valid"}, instr_valid, 1);
      cmp({name, "_err"}, addr_err, exp_e);
   endtask

   task automatic word(int d, bit last);
      prog_valid = 1; prog_data = 8'(d); prog_last = last;
      cyc();
      prog_valid = 0; prog_last = 0;
   endtask

   initial begin
      byte unsigned t3 [5] = '{8'h11, 8'h22, 8'h33, 8'hA9, 8'h4D};
      cyc(); cyc();
      reset = 0;
      cyc();
      cmp("rst_valid", instr_valid, 0);
      cmp("rst_len", prog_len, 5);
      cmp("rst_busy", prog_busy, 0);
      // 1: default image
      for (int a = 0; a < 5; a++) fetch(a, img[a], 0, "t1_fetch");
      // 2: zero fill and out of range
      fetch(5, 0, 0, "t2_addr5");
      fetch(40, 0, 1, "t2_addr40");
      cyc();
      cmp("t2_idle_valid", instr_valid, 0);
      // 3: short load
      prog_start = 1; cyc(); prog_start = 0;
      cmp("t3_busy", prog_busy, 1);
      word(8'h11, 0); word(8'h22, 0); word(8'h33, 1);
      cmp("t3_done", prog_done, 1);
      cmp("t3_len", prog_len, 3);
      cmp("t3_ready", prog_ready, 0);
      cyc();
      cmp("t3_done_pulse", prog_done, 0);
      for (int a = 0; a < 5; a++) fetch(a, t3[a], 0, "t3_fetch");
      // 4: full-depth load with auto exit, extra word ignored
      prog_start = 1; cyc(); prog_start = 0;
      for (int i = 0; i < 32; i++) word(8'h80 + i, 0);
      cmp("t4_done", prog_done, 1);
      cmp("t4_len", prog_len, 32);
      cmp("t4_busy", prog_busy, 0);
      word(8'hFF, 0);
      fetch(0, 8'h80, 0, "t4_mem0");
      fetch(31, 8'h9F, 0, "t4_mem31");
      // 5: start beats fetch, fetch blocked in LOAD, restart ignored in LOAD
      rd_en = 1; read_address = 8'd1; prog_start = 1;
      cyc();
      prog_start = 0;
      cmp("t5_valid", instr_valid, 0);
      cmp("t5_busy", prog_busy, 1);
      read_address = 8'd2;
      cyc();
      cmp("t5_load_valid", instr_valid, 0);
      cmp("t5_hold", instruction, 8'h9F);
      rd_en = 0;
      prog_start = 1; word(8'h55, 0); prog_start = 0;
      word(8'h56, 1);
      cmp("t5_len", prog_len, 2);
      fetch(0, 8'h55, 0, "t5_mem0");
      fetch(1, 8'h56, 0, "t5_mem1");
      fetch(2, 8'h82, 0, "t5_mem2");
      // 6: reset mid-load restores the default image
      prog_start = 1; cyc(); prog_start = 0;
      word(8'h66, 0); word(8'h77, 0);
      reset = 1; cyc(); reset = 0;
      cyc();
      cmp("t6_busy", prog_busy, 0);
      cmp("t6_len", prog_len, 5);
      fetch(0, 8'h49, 0, "t6_mem0");
      fetch(1, 8'hC1, 0, "t6_mem1");
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
